lc3_dmem_responder: RTL and testbench
=====================================

# lc3_dmem_responder

Data-memory responder for the pipelined LC3 core: the memory-side end of the `mem_state` / `complete_data` handshake that the pipeline controller drives. It accepts read, indirect-read and write requests, and models a fixed number of wait states. It performs the access on an internal word array, returns read data, and pulses `complete_data` for one cycle per finished access. It sits between the execute/memory-access datapath and the testbench or top-level, replacing an ideal zero-latency data memory.

## Interface
Parameters:
- `DEPTH`, 256: number of 16-bit words; power of two, 2..65536.
- `LATENCY`, 2: wait-state cycles between request acceptance and response; 0..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low (asserted when 0).
- `mem_state`  in  3  request code from controller.
  - 0: read.
  - 1: indirect-address read.
  - 2: write.
  - 3: idle.
  - 4..7: treated as idle.
- `D_addr`  in  16  word address of the access.
- `D_din`  in  16  write data.
- `DMem_dout`  out  16  read data.
- `complete_data`  out  1  one-cycle access-done pulse.
- `mem_err`  out  1  one-cycle out-of-range pulse; exists only with the macro enabled, otherwise tied 0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `mem_state` is in {0,1,2}, latch op, `D_addr` and `D_din`.
  - If `LATENCY`>0, load the wait counter with `LATENCY` and go to WAIT; if `LATENCY`==0, go to RESP.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - Input changes are ignored, except that `mem_state` ≥ 3 aborts: return to IDLE, no array access, no `complete_data`.
- RESP:
  - Perform the access using the latched values.
  - Read (0 or 1): `DMem_dout` <= mem[addr].
  - Write (2): mem[addr] <= latched data; `DMem_dout` is unchanged.
  - Assert `complete_data` for exactly one cycle, then go to IDLE.
- After RESP, IDLE ignores requests for one cycle (holdoff). This absorbs the controller's one-cycle-late `mem_state` update.
- Codes 0 and 1 behave identically on this side; the controller sequences the LDI/STI phases 1→0 and 1→2 itself.
- Address indexing uses `D_addr[log2(DEPTH)-1:0]`.
- `DMem_dout` holds the last read value until the next read response.
- The array is not reset; its contents survive `rst`.

## Timing
- Reset (`rst`==0 at an edge) sets:
  - FSM = IDLE, counter = 0, holdoff cleared.
  - `complete_data`=0, `DMem_dout`=16'h0000, `mem_err`=0.
- Reset in the middle of an operation discards the pending access; a pending write is not committed.
- Latency: a request seen in IDLE during cycle c produces `complete_data`=1 in cycle c+1+`LATENCY`. Read data is valid in that same cycle.
- Back-to-back requests: minimum spacing is `LATENCY`+3 cycles (accept, wait states, RESP, holdoff).
- Read-after-write to the same address returns the new data.
- A write and a later read cannot occur in the same cycle; there is no bypass.
- `complete_data` is never high for two consecutive cycles.

## Configuration
- `LC3_DMEM_OOR_EN` defined:
  - At acceptance, if `D_addr` ≥ `DEPTH`, the request is flagged.
  - At RESP, a flagged write is suppressed, and a flagged read returns 16'h0000.
  - `complete_data` and `mem_err` both pulse in that RESP cycle.
- `LC3_DMEM_OOR_EN` undefined: the address wraps modulo `DEPTH` and `mem_err` is constant 0.

## Test plan
- Write then read, `LATENCY`=2: write 16'hBEEF to 16'h0010 with `mem_state`=2 at cycle 5, giving `complete_data` at cycle 8. Then read 16'h0010 with `mem_state`=0, giving `DMem_dout`=16'hBEEF with `complete_data`=1.
- Indirect chain: set mem[16'h0020]=16'h0030 and mem[16'h0030]=16'h1234. Issue `mem_state`=1 at 16'h0020, which returns 16'h0030. Then issue `mem_state`=0 at 16'h0030, which returns 16'h1234. Expect exactly two `complete_data` pulses.
- Abort: a write to 16'h0005 with `mem_state` dropping to 3 one cycle after acceptance gives no `complete_data`, and mem[16'h0005] is unchanged.
- Reset mid-WAIT: `rst`=0 during a pending write of 16'hAAAA gives all outputs 0 the next cycle, and the old contents of that address are retained.
- `LATENCY`=0: a read accepted in cycle c gives `complete_data` in cycle c+1. Holding `mem_state`=0 continuously produces pulses every 3 cycles.
- OOR (macro on, `DEPTH`=256): a read of 16'h0100 gives `complete_data`=1, `mem_err`=1, `DMem_dout`=0. With the macro off, the same read returns mem[16'h0000].

Source files
------------

// File: rtl/lc3_dmem_responder.sv
// Data-memory responder for the pipelined LC3: IDLE/WAIT/RESP handshake with fixed wait states.
// Optional out-of-range checking is enabled by defining LC3_DMEM_OOR_EN.
module lc3_dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_state,
  input  logic [15:0] D_addr,
  input  logic [15:0] D_din,
  output logic [15:0] DMem_dout,
  output logic        complete_data,
  output logic        mem_err
);

  localparam int DATA_W = 16;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              holdoff;

  logic              op_we_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] din_q;
  logic              oor_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              req_we;
  logic              req_oor;
  logic              accept;
  logic              abort;

  logic              acc_go;
  logic              acc_we;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_din;
  logic              acc_oor;

  assign req    = (mem_state <= 3'd2);
  assign req_we = (mem_state == 3'd2);
  assign accept = (state == IDLE) && !holdoff && req;
  assign abort  = (mem_state >= 3'd3);

`ifdef LC3_DMEM_OOR_EN
  assign req_oor = ({1'b0, D_addr} >= 17'(DEPTH));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^D_addr;
  assign req_oor = 1'b0;
  assign mem_err = 1'b0;
`endif

  // The access fires on the edge that enters RESP, so data and complete_data
  // appear together during the RESP cycle. With no wait states that edge is
  // the acceptance edge itself, so the live inputs stand in for the latches.
  always_comb begin
    acc_go   = 1'b0;
    acc_we   = op_we_q;
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_oor  = oor_q;
    if (LATENCY == 0) begin
      if (accept) begin
        acc_go   = 1'b1;
        acc_we   = req_we;
        acc_addr = D_addr[AW-1:0];
        acc_din  = D_din;
        acc_oor  = req_oor;
      end
    end else if ((state == WAIT) && !abort && (cnt == 4'd1)) begin
      acc_go = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_we_q <= req_we;
      addr_q  <= D_addr[AW-1:0];
      din_q   <= D_din;
      oor_q   <= req_oor;
    end
  end

  // Writes are gated by reset so a pending write is dropped, never committed.
  always_ff @(posedge clk) begin
    if (rst && acc_go && acc_we && !acc_oor)
      mem[acc_addr] <= acc_din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      holdoff       <= 1'b0;
      complete_data <= 1'b0;
      DMem_dout     <= '0;
`ifdef LC3_DMEM_OOR_EN
      mem_err       <= 1'b0;
`endif
    end else begin
      complete_data <= acc_go;
`ifdef LC3_DMEM_OOR_EN
      mem_err       <= acc_go && acc_oor;
`endif
      if (acc_go && !acc_we)
        DMem_dout <= acc_oor ? '0 : mem[acc_addr];

      case (state)
        IDLE: begin
          if (holdoff) begin
            holdoff <= 1'b0;
          end else if (req) begin
            cnt   <= LAT;
            state <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          holdoff <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Directed bench for lc3_dmem_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_lc3_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [2:0]  ms   = 3'd3;
  logic [15:0] addr = '0;
  logic [15:0] din  = '0;
  logic [15:0] dout;
  logic        cd;
  logic        err;

  logic [2:0]  ms0   = 3'd3;
  logic [15:0] addr0 = '0;
  logic [15:0] din0  = '0;
  logic [15:0] dout0;
  logic        cd0;
  logic        err0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cd     = 0;

  always #5 clk = ~clk;

  lc3_dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .mem_state(ms), .D_addr(addr), .D_din(din),
    .DMem_dout(dout), .complete_data(cd), .mem_err(err)
  );

  lc3_dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_state(ms0), .D_addr(addr0), .D_din(din0),
    .DMem_dout(dout0), .complete_data(cd0), .mem_err(err0)
  );

  always @(negedge clk) if (cd === 1'b1) n_cd++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the LATENCY=2 instance, hold it until complete_data,
  // then drop to idle and step past the holdoff cycle.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat, output logic e);
    ms = op; addr = a; din = d; lat = 0; rd = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (cd === 1'b1) begin
        lat = i;
        break;
      end
    end
    rd = dout;
    e  = err;
    ms = 3'd3;
    tick;
    check("cd_single_pulse", {31'd0, cd}, 32'd0);
    tick;
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat;
  int          base;

  initial begin
    repeat (3) tick;
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_cd",   {31'd0, cd},   32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    rst = 1'b1;
    tick;

    // Write then read
    do_op(3'd2, 16'h0010, 16'hBEEF, rd, lat, e);
    check("wr_latency", lat, 3);
    check("wr_err", {31'd0, e}, 32'd0);
    check("wr_dout_hold", {16'd0, rd}, 32'd0);
    do_op(3'd0, 16'h0010, 16'h0000, rd, lat, e);
    check("rd_latency", lat, 3);
    check("rd_data", {16'd0, rd}, 32'h0000BEEF);

    // Indirect chain
    do_op(3'd2, 16'h0020, 16'h0030, rd, lat, e);
    do_op(3'd2, 16'h0030, 16'h1234, rd, lat, e);
    base = n_cd;
    do_op(3'd1, 16'h0020, 16'h0000, rd, lat, e);
    check("ind_ptr", {16'd0, rd}, 32'h00000030);
    do_op(3'd0, rd, 16'h0000, rd, lat, e);
    check("ind_data", {16'd0, rd}, 32'h00001234);
    check("ind_pulses", n_cd - base, 2);

    // Abort a write one cycle after acceptance
    do_op(3'd2, 16'h0005, 16'h5555, rd, lat, e);
    base = n_cd;
    ms = 3'd2; addr = 16'h0005; din = 16'h9999;
    tick;
    ms = 3'd3;
    repeat (5) tick;
    check("abort_no_cd", n_cd - base, 0);
    do_op(3'd0, 16'h0005, 16'h0000, rd, lat, e);
    check("abort_mem", {16'd0, rd}, 32'h00005555);

    // Reset while a write sits in WAIT
    do_op(3'd2, 16'h0040, 16'h1111, rd, lat, e);
    ms = 3'd2; addr = 16'h0040; din = 16'hAAAA;
    tick;
    tick;
    rst = 1'b0; ms = 3'd3;
    tick;
    check("midrst_dout", {16'd0, dout}, 32'd0);
    check("midrst_cd",   {31'd0, cd},   32'd0);
    check("midrst_err",  {31'd0, err},  32'd0);
    rst = 1'b1;
    tick;
    do_op(3'd0, 16'h0040, 16'h0000, rd, lat, e);
    check("midrst_mem", {16'd0, rd}, 32'h00001111);

    // Zero wait states: one write, then a held read pulses every 3 cycles
    ms0 = 3'd2; addr0 = 16'h0007; din0 = 16'h7777;
    tick;
    check("l0_wr_cd", {31'd0, cd0}, 32'd1);
    ms0 = 3'd3;
    tick;
    tick;
    ms0 = 3'd0; addr0 = 16'h0007;
    for (int i = 1; i <= 9; i++) begin
      tick;
      check("l0_pulse", {31'd0, cd0}, {31'd0, (i % 3 == 1)});
      if (i == 1) check("l0_data", {16'd0, dout0}, 32'h00007777);
    end
    ms0 = 3'd3;
    tick;

    // Out-of-range read
    do_op(3'd2, 16'h0000, 16'h0F0F, rd, lat, e);
    do_op(3'd0, 16'h0100, 16'h0000, rd, lat, e);
    check("oor_latency", lat, 3);
`ifdef LC3_DMEM_OOR_EN
    check("oor_data", {16'd0, rd}, 32'd0);
    check("oor_err", {31'd0, e}, 32'd1);
`else
    check("oor_data", {16'd0, rd}, 32'h00000F0F);
    check("oor_err", {31'd0, e}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
